id_ex_stage_reg: RTL and testbench

//  Decode->execute pipeline register, directly downstream of the decode control unit. Captures decode control and operands.

---
 rtl/id_ex_stage_reg_pkg.sv | 36 +++
 rtl/id_ex_stage_reg_hazard_detect.sv | 27 ++
 rtl/id_ex_stage_reg.sv | 127 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared encodings for the decode/execute boundary: result select, ALU ops, opcodes.
package id_ex_stage_reg_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic is_load_result(input logic [1:0] res_src);
        return res_src == RES_MEM;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Combinational load-use detection and fetch/decode stall/flush steering.
module id_ex_stage_reg_hazard_detect
    import id_ex_stage_reg_pkg::*;
(
    input  logic             valid_e,
    input  logic [1:0]       res_src_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             flush_e,
    input  logic             hold_e,
    output logic             load_use,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d
);

    // Source match is conservative: taken even if decode does not read rs1/rs2.
    always_comb begin
        load_use = valid_e && is_load_result(res_src_e) && (rd_e != '0)
                   && ((rs1_d == rd_e) || (rs2_d == rd_e));
        stall_f  = (load_use || hold_e) && !flush_e;
        stall_d  = stall_f;
        flush_d  = flush_e;
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and bubble counter.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_write_d,
    input  logic [1:0]       res_src_d,
    input  logic             mem_write_d,
    input  logic             jump_d,
    input  logic             branch_d,
    input  logic             alu_src_a_d,
    input  logic             alu_src_b_d,
    input  logic             adder_src_d,
    input  logic [3:0]       alu_control_d,
    input  logic [2:0]       funct3_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic [XLEN-1:0]  imm_ext_d,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_d,
    input  logic             flush_e,
    input  logic             hold_e,
    output logic             reg_write_e,
    output logic [1:0]       res_src_e,
    output logic             mem_write_e,
    output logic             jump_e,
    output logic             branch_e,
    output logic             alu_src_a_e,
    output logic             alu_src_b_e,
    output logic             adder_src_e,
    output logic [3:0]       alu_control_e,
    output logic [2:0]       funct3_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_plus4_e,
    output logic [XLEN-1:0]  imm_ext_e,
    output logic [REG_W-1:0] rs1_e,
    output logic [REG_W-1:0] rs2_e,
    output logic [REG_W-1:0] rd_e,
    output logic             valid_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic load_use;
    logic insert_bubble;

    id_ex_stage_reg_hazard_detect u_hazard_detect (
        .valid_e   (valid_e),
        .res_src_e (res_src_e),
        .rd_e      (rd_e),
        .rs1_d     (rs1_d),
        .rs2_d     (rs2_d),
        .flush_e   (flush_e),
        .hold_e    (hold_e),
        .load_use  (load_use),
        .stall_f   (stall_f),
        .stall_d   (stall_d),
        .flush_d   (flush_d)
    );

    // Flush beats hold; hold beats load-use.
    assign insert_bubble = flush_e || (load_use && !hold_e);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || insert_bubble) begin
            reg_write_e   <= 1'b0;
            res_src_e     <= '0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_src_a_e   <= 1'b0;
            alu_src_b_e   <= 1'b0;
            adder_src_e   <= 1'b0;
            alu_control_e <= '0;
            funct3_e      <= '0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            imm_ext_e     <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            valid_e       <= 1'b0;
        end else if (!hold_e) begin
            reg_write_e   <= reg_write_d;
            res_src_e     <= res_src_d;
            mem_write_e   <= mem_write_d;
            jump_e        <= jump_d;
            branch_e      <= branch_d;
            alu_src_a_e   <= alu_src_a_d;
            alu_src_b_e   <= alu_src_b_d;
            adder_src_e   <= adder_src_d;
            alu_control_e <= alu_control_d;
            funct3_e      <= funct3_d;
            rd1_e         <= rd1_d;
            rd2_e         <= rd2_d;
            pc_e          <= pc_d;
            pc_plus4_e    <= pc_plus4_d;
            imm_ext_e     <= imm_ext_d;
            rs1_e         <= rs1_d;
            rs2_e         <= rs2_d;
            rd_e          <= rd_d;
            valid_e       <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (insert_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; CNT_W=2 so counter saturation is reachable quickly.
module tb_id_ex_stage_reg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             rst = 1'b0;
    logic             reg_write_d = 1'b0;
    logic [1:0]       res_src_d = '0;
    logic             mem_write_d = 1'b0;
    logic             jump_d = 1'b0;
    logic             branch_d = 1'b0;
    logic             alu_src_a_d = 1'b0;
    logic             alu_src_b_d = 1'b0;
    logic             adder_src_d = 1'b0;
    logic [3:0]       alu_control_d = '0;
    logic [2:0]       funct3_d = '0;
    logic [XLEN-1:0]  rd1_d = '0;
    logic [XLEN-1:0]  rd2_d = '0;
    logic [XLEN-1:0]  pc_d = '0;
    logic [XLEN-1:0]  pc_plus4_d = '0;
    logic [XLEN-1:0]  imm_ext_d = '0;
    logic [4:0]       rs1_d = '0;
    logic [4:0]       rs2_d = '0;
    logic [4:0]       rd_d = '0;
    logic             flush_e = 1'b0;
    logic             hold_e = 1'b0;

    logic             reg_write_e;
    logic [1:0]       res_src_e;
    logic             mem_write_e;
    logic             jump_e;
    logic             branch_e;
    logic             alu_src_a_e;
    logic             alu_src_b_e;
    logic             adder_src_e;
    logic [3:0]       alu_control_e;
    logic [2:0]       funct3_e;
    logic [XLEN-1:0]  rd1_e;
    logic [XLEN-1:0]  rd2_e;
    logic [XLEN-1:0]  pc_e;
    logic [XLEN-1:0]  pc_plus4_e;
    logic [XLEN-1:0]  imm_ext_e;
    logic [4:0]       rs1_e;
    logic [4:0]       rs2_e;
    logic [4:0]       rd_e;
    logic             valid_e;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic [CNT_W-1:0] bubble_cnt;

    int total = 0;
    int bad = 0;

    id_ex_stage_reg #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_write_d   (reg_write_d),
        .res_src_d     (res_src_d),
        .mem_write_d   (mem_write_d),
        .jump_d        (jump_d),
        .branch_d      (branch_d),
        .alu_src_a_d   (alu_src_a_d),
        .alu_src_b_d   (alu_src_b_d),
        .adder_src_d   (adder_src_d),
        .alu_control_d (alu_control_d),
        .funct3_d      (funct3_d),
        .rd1_d         (rd1_d),
        .rd2_d         (rd2_d),
        .pc_d          (pc_d),
        .pc_plus4_d    (pc_plus4_d),
        .imm_ext_d     (imm_ext_d),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rd_d          (rd_d),
        .flush_e       (flush_e),
        .hold_e        (hold_e),
        .reg_write_e   (reg_write_e),
        .res_src_e     (res_src_e),
        .mem_write_e   (mem_write_e),
        .jump_e        (jump_e),
        .branch_e      (branch_e),
        .alu_src_a_e   (alu_src_a_e),
        .alu_src_b_e   (alu_src_b_e),
        .adder_src_e   (adder_src_e),
        .alu_control_e (alu_control_e),
        .funct3_e      (funct3_e),
        .rd1_e         (rd1_e),
        .rd2_e         (rd2_e),
        .pc_e          (pc_e),
        .pc_plus4_e    (pc_plus4_e),
        .imm_ext_e     (imm_ext_e),
        .rs1_e         (rs1_e),
        .rs2_e         (rs2_e),
        .rd_e          (rd_e),
        .valid_e       (valid_e),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .bubble_cnt    (bubble_cnt)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one decode instruction; data fields derived from rd so they are distinct.
    task automatic set_instr(input logic rw, input logic [1:0] rs, input logic [3:0] alu,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        reg_write_d   = rw;
        res_src_d     = rs;
        alu_control_d = alu;
        rs1_d         = r1;
        rs2_d         = r2;
        rd_d          = rd;
        rd1_d         = 32'h1000 + 32'(rd);
        rd2_d         = 32'h2000 + 32'(rd);
        pc_d          = 32'h100 + (32'(rd) << 2);
        pc_plus4_d    = pc_d + 32'd4;
        imm_ext_d     = 32'h30 + 32'(rd);
        funct3_d      = (rs == 2'b01) ? 3'b010 : 3'b000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1: async reset with clock idle
        #2 rst = 1'b1;
        #1;
        check_eq("t1_valid", 32'(valid_e), 32'd0);
        check_eq("t1_rd", 32'(rd_e), 32'd0);
        check_eq("t1_rw", 32'(reg_write_e), 32'd0);
        check_eq("t1_rd1", rd1_e, 32'd0);
        check_eq("t1_cnt", 32'(bubble_cnt), 32'd0);
        #2 rst = 1'b0;
        clk_en = 1'b1;
        #1;

        // T2: add x3,x1,x2 passes through
        set_instr(1'b1, 2'b00, 4'b0000, 5'd1, 5'd2, 5'd3);
        #1 check_eq("t2_stall_pre", 32'(stall_f), 32'd0);
        step();
        check_eq("t2_rd", 32'(rd_e), 32'd3);
        check_eq("t2_rw", 32'(reg_write_e), 32'd1);
        check_eq("t2_valid", 32'(valid_e), 32'd1);
        check_eq("t2_rd1", rd1_e, 32'h1003);
        check_eq("t2_pc4", pc_plus4_e, 32'h110);
        check_eq("t2_stall_d", 32'(stall_d), 32'd0);

        // T3: lw x5 then add x6,x5,x7
        set_instr(1'b1, 2'b01, 4'b0000, 5'd2, 5'd0, 5'd5);
        step();
        check_eq("t3_lw_res", 32'(res_src_e), 32'd1);
        set_instr(1'b1, 2'b00, 4'b0000, 5'd5, 5'd7, 5'd6);
        #1;
        check_eq("t3_stall_f", 32'(stall_f), 32'd1);
        check_eq("t3_stall_d", 32'(stall_d), 32'd1);
        check_eq("t3_flush_d", 32'(flush_d), 32'd0);
        step();
        check_eq("t3_bub_valid", 32'(valid_e), 32'd0);
        check_eq("t3_bub_rw", 32'(reg_write_e), 32'd0);
        check_eq("t3_bub_rd1", rd1_e, 32'd0);
        check_eq("t3_cnt", 32'(bubble_cnt), 32'd1);
        check_eq("t3_unstall", 32'(stall_f), 32'd0);
        step();
        check_eq("t3_add_rd", 32'(rd_e), 32'd6);
        check_eq("t3_add_valid", 32'(valid_e), 32'd1);
        check_eq("t3_cnt_keep", 32'(bubble_cnt), 32'd1);

        // hold freezes the register without counting a bubble
        hold_e = 1'b1;
        set_instr(1'b0, 2'b10, 4'b1101, 5'd9, 5'd9, 5'd9);
        #1 check_eq("hold_stall", 32'(stall_f), 32'd1);
        step();
        check_eq("hold_rd", 32'(rd_e), 32'd6);
        check_eq("hold_rw", 32'(reg_write_e), 32'd1);
        check_eq("hold_cnt", 32'(bubble_cnt), 32'd1);
        hold_e = 1'b0;

        // T4: flush beats hold and load-use
        set_instr(1'b1, 2'b01, 4'b0000, 5'd1, 5'd0, 5'd8);
        step();
        set_instr(1'b1, 2'b00, 4'b0000, 5'd8, 5'd2, 5'd4);
        hold_e = 1'b1;
        flush_e = 1'b1;
        #1;
        check_eq("t4_stall_f", 32'(stall_f), 32'd0);
        check_eq("t4_stall_d", 32'(stall_d), 32'd0);
        check_eq("t4_flush_d", 32'(flush_d), 32'd1);
        step();
        check_eq("t4_valid", 32'(valid_e), 32'd0);
        check_eq("t4_rd", 32'(rd_e), 32'd0);
        check_eq("t4_cnt", 32'(bubble_cnt), 32'd2);
        hold_e = 1'b0;
        flush_e = 1'b0;

        // T5: lw x0 never creates a hazard
        set_instr(1'b1, 2'b01, 4'b0000, 5'd2, 5'd0, 5'd0);
        step();
        set_instr(1'b1, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd1);
        #1 check_eq("t5_stall", 32'(stall_f), 32'd0);
        step();
        check_eq("t5_rd", 32'(rd_e), 32'd1);
        check_eq("t5_valid", 32'(valid_e), 32'd1);
        check_eq("t5_cnt", 32'(bubble_cnt), 32'd2);

        // Back-to-back dependent loads: lw x9; lw x10,0(x9); add x11,x10,x0
        set_instr(1'b1, 2'b01, 4'b0000, 5'd2, 5'd0, 5'd9);
        step();
        set_instr(1'b1, 2'b01, 4'b0000, 5'd9, 5'd0, 5'd10);
        #1 check_eq("b2b_stall1", 32'(stall_f), 32'd1);
        step();
        check_eq("b2b_bub1", 32'(valid_e), 32'd0);
        step();
        check_eq("b2b_lw2_rd", 32'(rd_e), 32'd10);
        set_instr(1'b1, 2'b00, 4'b0000, 5'd10, 5'd0, 5'd11);
        #1 check_eq("b2b_stall2", 32'(stall_f), 32'd1);

        // T7: reset mid-stall acts without a clock edge
        rst = 1'b1;
        #1;
        check_eq("t7_valid", 32'(valid_e), 32'd0);
        check_eq("t7_rd", 32'(rd_e), 32'd0);
        check_eq("t7_cnt", 32'(bubble_cnt), 32'd0);
        check_eq("t7_stall", 32'(stall_f), 32'd0);
        rst = 1'b0;
        step();
        check_eq("t7_rd_after", 32'(rd_e), 32'd11);
        check_eq("t7_valid_after", 32'(valid_e), 32'd1);

        // T6: saturation with CNT_W=2 after five flushes
        flush_e = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq($sformatf("t6_cnt%0d", i), 32'(bubble_cnt), (i < 3) ? 32'(i) : 32'd3);
        end
        flush_e = 1'b0;
        step();
        check_eq("t6_cnt_hold", 32'(bubble_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
